// File: rtl/oled_link_arbiter_pkg.sv
// rtl/oled_link_arbiter_pkg.sv - shared OLED word format, arbiter state encoding and SSD command constants
package oled_pkg;

  localparam int OLED_WORD_W = 9;
  localparam int DC_BIT      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_ACKED     = 2'd2,
    ST_HOLD      = 2'd3
  } arb_state_t;

  localparam logic [7:0] SSD_SET_COLUMN = 8'h15;
  localparam logic [7:0] SSD_SET_ROW    = 8'h75;
  localparam logic [7:0] SSD_WRITE_RAM  = 8'h5C;
  localparam logic [7:0] SSD_DISPLAY_ON = 8'hAF;

endpackage

// File: rtl/oled_link_arbiter_rr_pick.sv
// rtl/oled_link_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_onehot,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int IW = $clog2(NUM_REQ);

  // Scan from farthest to nearest so the candidate just after i_ptr overrides all others
  always_comb begin
    int c;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    c        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[c]) begin
        o_onehot    = '0;
        o_onehot[c] = 1'b1;
        o_idx       = IW'(c);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_link_arbiter.sv
// rtl/oled_link_arbiter.sv - transaction-locked round-robin arbiter in front of the OLED word serializer
module oled_link_arbiter
  import oled_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int HOLD_TIMEOUT = 255,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                           i_clk,
  input  logic                           i_rstb,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [OLED_WORD_W*NUM_REQ-1:0] i_req_dat,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ack,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_ser_go,
  output logic [OLED_WORD_W-1:0]         o_ser_dat,
  input  logic                           i_ser_done,
  output logic                           o_link_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  localparam int DW = $clog2(DONE_TIMEOUT + 1);

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0]     r_grant, r_ack;
  logic [IW-1:0]          r_gidx, r_rr_ptr;
  logic                   r_last, r_ser_go, r_link_err;
  logic [OLED_WORD_W-1:0] r_ser_dat;
  logic [DW-1:0]          r_done_cnt, w_done_inc;
  logic [HW-1:0]          r_hold_cnt, w_hold_inc;

  logic [NUM_REQ-1:0]     w_pick_oh;
  logic [IW-1:0]          w_pick_idx, w_sel_idx;
  logic                   w_pick_any;
  logic                   w_launch, w_ack, w_release, w_set_err;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req    (i_req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // New owner comes from the picker in IDLE, otherwise the locked owner keeps the link
  assign w_sel_idx  = (r_state == ST_IDLE) ? w_pick_idx : r_gidx;
  assign w_done_inc = (r_done_cnt == DW'(DONE_TIMEOUT)) ? r_done_cnt : r_done_cnt + DW'(1);
  assign w_hold_inc = (r_hold_cnt == HW'(HOLD_TIMEOUT)) ? r_hold_cnt : r_hold_cnt + HW'(1);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstb) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; SER_DONE beats a coincident done timeout
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_ack       = 1'b0;
    w_release   = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_ser_done) begin
          w_ack = 1'b1;
          if (r_last) begin
            w_release   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ACKED;
          end
        end else if (w_done_inc == DW'(DONE_TIMEOUT)) begin
          w_set_err   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACKED: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (i_req[r_gidx]) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else if (w_hold_inc == HW'(HOLD_TIMEOUT)) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: grant lock, serializer word, ack pulse, fairness pointer and timeout counters
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= IW'(NUM_REQ - 1);
      r_ack      <= '0;
      r_last     <= 1'b0;
      r_ser_go   <= 1'b0;
      r_ser_dat  <= '0;
      r_link_err <= 1'b0;
      r_done_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_ser_go <= w_launch;
      r_ack    <= w_ack ? r_grant : '0;
      if (w_launch) begin
        if (r_state == ST_IDLE) begin
          r_grant <= w_pick_oh;
          r_gidx  <= w_pick_idx;
        end
        r_ser_dat <= i_req_dat[w_sel_idx*OLED_WORD_W +: OLED_WORD_W];
        r_last    <= i_req_last[w_sel_idx];
      end
      if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= r_gidx;
      end
      if (w_set_err) r_link_err <= 1'b1;
      if (r_state == ST_WAIT_DONE && w_state_nxt == ST_WAIT_DONE) r_done_cnt <= w_done_inc;
      else                                                        r_done_cnt <= '0;
      if (r_state == ST_HOLD && w_state_nxt == ST_HOLD) r_hold_cnt <= w_hold_inc;
      else                                              r_hold_cnt <= '0;
    end
  end

  assign o_grant    = r_grant;
  assign o_req_ack  = r_ack;
  assign o_ser_go   = r_ser_go;
  assign o_ser_dat  = r_ser_dat;
  assign o_link_err = r_link_err;

endmodule

// File: tb/tb_oled_link_arbiter.sv
// tb/tb_oled_link_arbiter.sv - directed self-checking bench for oled_link_arbiter
module tb_oled_link_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic [2:0]  req;
  logic [26:0] req_dat;
  logic [2:0]  req_last;
  logic        ser_done;
  logic        e_ser_done;
  logic [2:0]  req_ack, grant;
  logic        ser_go, link_err;
  logic [8:0]  ser_dat;
  logic [2:0]  e_req_ack, e_grant;
  logic        e_ser_go, e_link_err;
  logic [8:0]  e_ser_dat;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ser_lat = 18;
  logic [8:0] go_q[$];
  logic [2:0] go_own[$];
  int         go_t[$];
  int         ack_cnt[3];
  int         e_ack_total = 0;
  int         e_go_t = 0;

  always #5 clk = ~clk;

  oled_link_arbiter #(.NUM_REQ(3), .HOLD_TIMEOUT(8), .DONE_TIMEOUT(32)) dut (
    .i_clk(clk), .i_rstb(rstb), .i_req(req), .i_req_dat(req_dat), .i_req_last(req_last),
    .o_req_ack(req_ack), .o_grant(grant), .o_ser_go(ser_go), .o_ser_dat(ser_dat),
    .i_ser_done(ser_done), .o_link_err(link_err)
  );

  oled_link_arbiter #(.NUM_REQ(3), .HOLD_TIMEOUT(8), .DONE_TIMEOUT(16)) dut_e (
    .i_clk(clk), .i_rstb(rstb), .i_req(req), .i_req_dat(req_dat), .i_req_last(req_last),
    .o_req_ack(e_req_ack), .o_grant(e_grant), .o_ser_go(e_ser_go), .o_ser_dat(e_ser_dat),
    .i_ser_done(e_ser_done), .o_link_err(e_link_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ser_go) begin
      go_q.push_back(ser_dat);
      go_own.push_back(grant);
      go_t.push_back(cyc);
    end
    if (e_ser_go) e_go_t = cyc;
    for (int i = 0; i < 3; i++) if (req_ack[i]) ack_cnt[i]++;
    if (e_req_ack != 3'b000) e_ack_total++;
  end

  initial begin
    ser_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ser_go) begin
        repeat (ser_lat) @(posedge clk);
        #1 ser_done = 1'b1;
        @(posedge clk);
        #1 ser_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    go_q.delete();
    go_own.delete();
    go_t.delete();
    for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
    e_ack_total = 0;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    req = '0;
    req_last = '0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    clear_logs();
  endtask

  task automatic send_word(input int r, input logic [8:0] w, input logic l);
    int k;
    req_dat[r*9 +: 9] = w;
    req_last[r] = l;
    req[r] = 1'b1;
    k = 0;
    while (k < 200) begin
      @(posedge clk); #1;
      if (req_ack[r]) break;
      k++;
    end
    if (k >= 200) check("ack_wait", 32'(k), 32'(0));
    req[r] = 1'b0;
  endtask

  initial begin
    int t0, k;
    rstb = 1'b0;
    req = '0;
    req_dat = '0;
    req_last = '0;
    e_ser_done = 1'b0;
    do_reset();

    // reset state
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_go", 32'(ser_go), 32'(0));
    check("rst_dat", 32'(ser_dat), 32'(0));
    check("rst_ack", 32'(req_ack), 32'(0));
    check("rst_err", 32'(link_err), 32'(0));

    // single 3-word transaction on req0, 18-cycle serializer
    ser_lat = 18;
    t0 = cyc;
    send_word(0, 9'h015, 1'b0);
    check("t1_grant_a", 32'(grant), 32'(3'b001));
    send_word(0, 9'h100, 1'b0);
    check("t1_grant_b", 32'(grant), 32'(3'b001));
    send_word(0, 9'h17F, 1'b1);
    check("t1_grant_clr", 32'(grant), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("t1_ngo", 32'(go_q.size()), 32'(3));
    if (go_q.size() == 3) begin
      check("t1_w0", 32'(go_q[0]), 32'(9'h015));
      check("t1_w1", 32'(go_q[1]), 32'(9'h100));
      check("t1_w2", 32'(go_q[2]), 32'(9'h17F));
      for (int i = 0; i < 3; i++) check("t1_own", 32'(go_own[i]), 32'(3'b001));
      check("t1_latency", 32'(go_t[0] - t0), 32'(1));
      check("t1_rate", 32'(go_t[1] - go_t[0]), 32'(21));
    end
    check("t1_acks", 32'(ack_cnt[0]), 32'(3));
    check("t1_dat_hold", 32'(ser_dat), 32'(9'h17F));

    // req0 and req2 together out of reset: req0 first, then req2 before req0 again
    do_reset();
    ser_lat = 4;
    fork
      begin
        send_word(0, 9'h0A1, 1'b0);
        send_word(0, 9'h0A2, 1'b1);
        send_word(0, 9'h0A3, 1'b1);
      end
      send_word(2, 9'h1D4, 1'b1);
    join
    check("t2_ngo", 32'(go_q.size()), 32'(4));
    if (go_q.size() == 4) begin
      check("t2_w0", 32'(go_q[0]), 32'(9'h0A1));
      check("t2_w1", 32'(go_q[1]), 32'(9'h0A2));
      check("t2_w2", 32'(go_q[2]), 32'(9'h1D4));
      check("t2_w3", 32'(go_q[3]), 32'(9'h0A3));
      check("t2_own2", 32'(go_own[2]), 32'(3'b100));
    end

    // req1 mid-transaction blocks req0 until its last word
    do_reset();
    fork
      begin
        send_word(1, 9'h0E1, 1'b0);
        send_word(1, 9'h0E2, 1'b0);
        send_word(1, 9'h1E3, 1'b1);
      end
      begin
        k = 0;
        while (k < 50 && grant != 3'b010) begin
          @(posedge clk); #1;
          k++;
        end
        check("t3_grant1", 32'(grant), 32'(3'b010));
        send_word(0, 9'h0F0, 1'b1);
      end
    join
    check("t3_ngo", 32'(go_q.size()), 32'(4));
    if (go_q.size() == 4) begin
      check("t3_w0", 32'(go_q[0]), 32'(9'h0E1));
      check("t3_w1", 32'(go_q[1]), 32'(9'h0E2));
      check("t3_w2", 32'(go_q[2]), 32'(9'h1E3));
      check("t3_w3", 32'(go_q[3]), 32'(9'h0F0));
    end

    // hold timeout: req0 drops REQ after a non-last ack, req1 waiting
    do_reset();
    send_word(0, 9'h033, 1'b0);
    t0 = cyc;
    req_dat[9 +: 9] = 9'h144;
    req_last[1] = 1'b1;
    req[1] = 1'b1;
    k = 0;
    while (k < 40 && grant == 3'b001) begin
      @(posedge clk); #1;
      k++;
    end
    check("t4_hold_time", 32'(cyc - t0), 32'(9));
    check("t4_grant_free", 32'(grant), 32'(0));
    @(posedge clk); #1;
    check("t4_grant1", 32'(grant), 32'(3'b010));
    check("t4_go_dat", 32'(ser_dat), 32'(9'h144));
    send_word(1, 9'h144, 1'b1);

    // done timeout on the second instance, serializer never answers
    do_reset();
    send_word(0, 9'h055, 1'b1);
    k = 0;
    while (k < 40 && !e_link_err) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_err", 32'(e_link_err), 32'(1));
    check("t5_err_time", 32'(cyc - e_go_t), 32'(16));
    check("t5_grant", 32'(e_grant), 32'(0));
    check("t5_noack", 32'(e_ack_total), 32'(0));
    repeat (5) @(posedge clk);
    #1;
    check("t5_sticky", 32'(e_link_err), 32'(1));
    rstb = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    check("t5_err_clr", 32'(e_link_err), 32'(0));

    // reset pulse during WAIT_DONE; the later SER_DONE must be ignored
    do_reset();
    ser_lat = 10;
    req_dat[0 +: 9] = 9'h1AA;
    req_last[0] = 1'b1;
    req[0] = 1'b1;
    k = 0;
    while (k < 20 && !ser_go) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6_go", 32'(ser_go), 32'(1));
    @(posedge clk); #1;
    rstb = 1'b0;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    check("t6_grant", 32'(grant), 32'(0));
    check("t6_go_off", 32'(ser_go), 32'(0));
    check("t6_dat", 32'(ser_dat), 32'(0));
    check("t6_ack", 32'(req_ack), 32'(0));
    check("t6_err", 32'(link_err), 32'(0));
    clear_logs();
    repeat (15) @(posedge clk);
    #1;
    check("t6_noack", 32'(ack_cnt[0]), 32'(0));
    check("t6_nogo", 32'(go_q.size()), 32'(0));
    check("t6_idle_grant", 32'(grant), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
